// File: rtl/sbox_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | sbox_share_sched                                                           |
// | Round-robin, non-preemptive sharing of one S-box between the key-schedule  |
// | port (SubWord) and the datapath port (SubBytes/InvSubBytes), 1 byte/cycle. |
// | Optional macro SBOX_PIPE_EN: registered S-box inputs, one drain cycle/job. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sbox_share_sched #(
    parameter int KEY_BYTES  = 4,
    parameter int DATA_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_start,
    input  logic [8*KEY_BYTES-1:0]  key_word,
    output logic                    key_ready,
    output logic                    key_done,
    output logic [8*KEY_BYTES-1:0]  key_sub,
    input  logic                    data_start,
    input  logic                    data_encrypt,
    input  logic [8*DATA_BYTES-1:0] data_state,
    output logic                    data_ready,
    output logic                    data_done,
    output logic [8*DATA_BYTES-1:0] data_sub,
    output logic [7:0]              sbox_a,
    output logic                    sbox_encrypt,
    input  logic [7:0]              sbox_q,
    output logic                    busy
);
    localparam int c_max_bytes = (KEY_BYTES > DATA_BYTES) ? KEY_BYTES : DATA_BYTES;
`ifdef SBOX_PIPE_EN
    localparam int c_pipe = 1;
`else
    localparam int c_pipe = 0;
`endif
    localparam int c_cnt_w = (c_max_bytes + c_pipe > 1) ? $clog2(c_max_bytes + c_pipe) : 1;
    localparam logic [c_cnt_w-1:0] c_key_last  = c_cnt_w'(KEY_BYTES - 1 + c_pipe);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_BYTES - 1 + c_pipe);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_KEY  = 2'd1,
        S_RUN_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_key_pend;
    logic                    r_data_pend;
    logic                    r_last_data;
    logic [8*KEY_BYTES-1:0]  r_key_word;
    logic [8*DATA_BYTES-1:0] r_data_state;
    logic                    r_data_enc;
    logic [8*KEY_BYTES-1:0]  r_key_sub;
    logic [8*DATA_BYTES-1:0] r_data_sub;
    logic                    r_key_done;
    logic                    r_data_done;

    logic                    w_key_acc;
    logic                    w_data_acc;
    logic                    w_key_req;
    logic                    w_data_req;
    logic                    w_at_last;
    logic                    w_issue_ok;
    logic                    w_cap_en;
    logic [c_cnt_w-1:0]      w_cap_idx;
    logic [7:0]              w_issue_a;
    logic                    w_issue_enc;

    assign w_key_acc  = key_start  & ~r_key_pend;
    assign w_data_acc = data_start & ~r_data_pend;
    // A start accepted this cycle competes for dispatch immediately.
    assign w_key_req  = r_key_pend  | w_key_acc;
    assign w_data_req = r_data_pend | w_data_acc;
    assign w_at_last  = (r_cnt == ((r_state == S_RUN_KEY) ? c_key_last : c_data_last));

`ifdef SBOX_PIPE_EN
    // Issue runs one cycle ahead of capture; the final RUN cycle only drains.
    assign w_issue_ok = ~w_at_last;
    assign w_cap_en   = (r_cnt != '0);
    assign w_cap_idx  = c_cnt_w'(r_cnt - 1'b1);
`else
    assign w_issue_ok = 1'b1;
    assign w_cap_en   = 1'b1;
    assign w_cap_idx  = r_cnt;
`endif

    always_comb begin
        w_issue_a   = 8'h00;
        w_issue_enc = 1'b1;
        if (r_state == S_RUN_KEY && w_issue_ok) begin
            for (int b = 0; b < KEY_BYTES; b++)
                if (r_cnt == c_cnt_w'(b)) w_issue_a = r_key_word[8*b +: 8];
        end else if (r_state == S_RUN_DATA && w_issue_ok) begin
            w_issue_enc = r_data_enc;
            for (int b = 0; b < DATA_BYTES; b++)
                if (r_cnt == c_cnt_w'(b)) w_issue_a = r_data_state[8*b +: 8];
        end
    end

`ifdef SBOX_PIPE_EN
    logic [7:0] r_sbox_a;
    logic       r_sbox_enc;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sbox_a   <= 8'h00;
            r_sbox_enc <= 1'b1;
        end else begin
            r_sbox_a   <= w_issue_a;
            r_sbox_enc <= w_issue_enc;
        end
    end
    assign sbox_a       = r_sbox_a;
    assign sbox_encrypt = r_sbox_enc;
`else
    assign sbox_a       = w_issue_a;
    assign sbox_encrypt = w_issue_enc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_key_pend   <= 1'b0;
            r_data_pend  <= 1'b0;
            r_last_data  <= 1'b1;
            r_key_word   <= '0;
            r_data_state <= '0;
            r_data_enc   <= 1'b1;
            r_key_sub    <= '0;
            r_data_sub   <= '0;
            r_key_done   <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_key_done  <= 1'b0;
            r_data_done <= 1'b0;
            if (w_key_acc) begin
                r_key_word <= key_word;
                r_key_pend <= 1'b1;
            end
            if (w_data_acc) begin
                r_data_state <= data_state;
                r_data_enc   <= data_encrypt;
                r_data_pend  <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_key_req && (!w_data_req || r_last_data)) r_state <= S_RUN_KEY;
                    else if (w_data_req)                           r_state <= S_RUN_DATA;
                end
                S_RUN_KEY: begin
                    for (int b = 0; b < KEY_BYTES; b++)
                        if (w_cap_en && w_cap_idx == c_cnt_w'(b)) r_key_sub[8*b +: 8] <= sbox_q;
                    if (w_at_last) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_key_done  <= 1'b1;
                        r_key_pend  <= 1'b0;
                        r_last_data <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN_DATA: begin
                    for (int b = 0; b < DATA_BYTES; b++)
                        if (w_cap_en && w_cap_idx == c_cnt_w'(b)) r_data_sub[8*b +: 8] <= sbox_q;
                    if (w_at_last) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_data_done <= 1'b1;
                        r_data_pend <= 1'b0;
                        r_last_data <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_ready  = ~r_key_pend;
    assign data_ready = ~r_data_pend;
    assign key_done   = r_key_done;
    assign data_done  = r_data_done;
    assign key_sub    = r_key_sub;
    assign data_sub   = r_data_sub;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sbox_share_sched                                                        |
// | Randomized self-checking bench with an AES S-box model and job timing model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sbox_share_sched;
    localparam int KB = 4;
    localparam int DB = 16;
`ifdef SBOX_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            key_start, key_ready, key_done;
    logic [8*KB-1:0] key_word, key_sub;
    logic            data_start, data_encrypt, data_ready, data_done;
    logic [8*DB-1:0] data_state, data_sub;
    logic [7:0]      sbox_a, sbox_q;
    logic            sbox_encrypt, busy;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int kd_q[$];
    int dd_q[$];
    logic enc_log [4096];

    logic [8*KB-1:0] exp_key_sub;
    logic [8*DB-1:0] exp_data_sub;
    logic            exp_last_data;

    sbox_share_sched #(.KEY_BYTES(KB), .DATA_BYTES(DB)) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_word(key_word), .key_ready(key_ready),
        .key_done(key_done), .key_sub(key_sub),
        .data_start(data_start), .data_encrypt(data_encrypt), .data_state(data_state),
        .data_ready(data_ready), .data_done(data_done), .data_sub(data_sub),
        .sbox_a(sbox_a), .sbox_encrypt(sbox_encrypt), .sbox_q(sbox_q), .busy(busy)
    );

    // Behavioural bSbox: combinational lookup in both directions.
    assign sbox_q = sbox_encrypt ? fwd_tab[sbox_a] : inv_tab[sbox_a];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_done)  kd_q.push_back(cyc);
        if (data_done) dd_q.push_back(cyc);
        enc_log[cyc % 4096] = sbox_encrypt;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, r;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            s = s ^ 8'h63;
            fwd_tab[a] = s;
            inv_tab[s] = 8'(a);
        end
    endtask

    function automatic logic [8*KB-1:0] sub_word(input logic [8*KB-1:0] w);
        logic [8*KB-1:0] r;
        for (int k = 0; k < KB; k++) r[8*k +: 8] = fwd_tab[w[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [8*DB-1:0] sub_state(input logic [8*DB-1:0] s, input logic enc);
        logic [8*DB-1:0] r;
        for (int k = 0; k < DB; k++) r[8*k +: 8] = enc ? fwd_tab[s[8*k +: 8]] : inv_tab[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [8*DB-1:0] rand_state();
        logic [8*DB-1:0] r;
        for (int k = 0; k < DB / 4; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a start for one edge; t0 is the cycle counter value in relative cycle 1.
    task automatic start_jobs(input logic k, input logic [8*KB-1:0] kw,
                              input logic d, input logic [8*DB-1:0] ds, input logic de,
                              output int t0);
        @(negedge clk);
        key_start = k;  key_word = kw;
        data_start = d; data_state = ds; data_encrypt = de;
        @(negedge clk);
        key_start = 1'b0;
        data_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_start = 1'b0; key_word = '0;
        data_start = 1'b0; data_state = '0; data_encrypt = 1'b0;
        tick(3);
        n_checks++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b exp 1", key_ready); else n_pass++;
        n_checks++; if (data_ready !== 1'b1) $display("FAIL reset_data_ready got %b exp 1", data_ready); else n_pass++;
        n_checks++; if ({key_done, data_done} !== 2'b00) $display("FAIL reset_done got %b exp 00", {key_done, data_done}); else n_pass++;
        n_checks++; if (key_sub !== '0) $display("FAIL reset_key_sub got %h exp 0", key_sub); else n_pass++;
        n_checks++; if (data_sub !== '0) $display("FAIL reset_data_sub got %h exp 0", data_sub); else n_pass++;
        n_checks++; if (sbox_a !== 8'h00) $display("FAIL reset_sbox_a got %h exp 00", sbox_a); else n_pass++;
        n_checks++; if (sbox_encrypt !== 1'b1) $display("FAIL reset_sbox_encrypt got %b exp 1", sbox_encrypt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        rst = 1'b0;
        exp_key_sub = '0; exp_data_sub = '0; exp_last_data = 1'b1;
        tick(1);
    endtask

    task automatic test_key();
        int t0;
        logic [8*KB-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 32'h00000053 : 32'($urandom);
            kd_q.delete(); dd_q.delete();
            start_jobs(1'b1, w, 1'b0, '0, 1'b0, t0);
            n_checks++; if ({key_ready, busy} !== 2'b01) $display("FAIL key_run_flags got ready/busy %b exp 01", {key_ready, busy}); else n_pass++;
            tick(KB + P);
            n_checks++; if ({key_done, key_ready} !== 2'b11) $display("FAIL key_done_cycle got done/ready %b exp 11", {key_done, key_ready}); else n_pass++;
            exp_key_sub = sub_word(w);
            exp_last_data = 1'b0;
            tick(3);
            n_checks++; if (key_sub !== exp_key_sub) $display("FAIL key_sub got %h exp %h", key_sub, exp_key_sub); else n_pass++;
            if (i == 0) begin
                n_checks++; if (key_sub !== 32'h636363ED) $display("FAIL key_sub_known got %h exp 636363ed", key_sub); else n_pass++;
            end
            n_checks++;
            if (kd_q.size() != 1 || kd_q[0] - t0 + 1 != KB + 1 + P)
                $display("FAIL key_latency got %0d pulses first rel %0d exp 1 at %0d", kd_q.size(),
                         (kd_q.size() > 0) ? kd_q[0] - t0 + 1 : -1, KB + 1 + P);
            else n_pass++;
            n_checks++; if (data_sub !== exp_data_sub) $display("FAIL key_data_sub_kept got %h exp %h", data_sub, exp_data_sub); else n_pass++;
        end
    endtask

    task automatic test_data();
        int t0;
        logic [8*DB-1:0] s;
        logic e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      begin s = {DB{8'h01}}; e = 1'b1; end
            else if (i == 1) begin s = {DB{8'h63}}; e = 1'b0; end
            else             begin s = rand_state(); e = i[0]; end
            kd_q.delete(); dd_q.delete();
            start_jobs(1'b0, '0, 1'b1, s, e, t0);
            n_checks++; if (data_ready !== 1'b0) $display("FAIL data_ready_run got %b exp 0", data_ready); else n_pass++;
            tick(DB + P);
            n_checks++; if ({data_done, data_ready} !== 2'b11) $display("FAIL data_done_cycle got done/ready %b exp 11", {data_done, data_ready}); else n_pass++;
            exp_data_sub = sub_state(s, e);
            exp_last_data = 1'b1;
            tick(3);
            n_checks++; if (data_sub !== exp_data_sub) $display("FAIL data_sub got %h exp %h", data_sub, exp_data_sub); else n_pass++;
            if (i < 2) begin
                n_checks++;
                if (data_sub !== ((i == 0) ? {DB{8'h7C}} : {DB{8'h00}}))
                    $display("FAIL data_sub_known got %h exp %s", data_sub, (i == 0) ? "all 7c" : "all 00");
                else n_pass++;
            end
            n_checks++;
            if (dd_q.size() != 1 || dd_q[0] - t0 + 1 != DB + 1 + P)
                $display("FAIL data_latency got %0d pulses first rel %0d exp 1 at %0d", dd_q.size(),
                         (dd_q.size() > 0) ? dd_q[0] - t0 + 1 : -1, DB + 1 + P);
            else n_pass++;
            n_checks++; if (key_sub !== exp_key_sub) $display("FAIL data_key_sub_kept got %h exp %h", key_sub, exp_key_sub); else n_pass++;
        end
    endtask

    task automatic test_both();
        int t0, kexp, dexp, first_done, bad;
        logic [8*KB-1:0] w;
        logic [8*DB-1:0] s;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                // Serve the key port alone so the next tie goes to the data port.
                kd_q.delete();
                w = 32'($urandom);
                start_jobs(1'b1, w, 1'b0, '0, 1'b0, t0);
                tick(KB + P + 4);
                exp_key_sub = sub_word(w);
                exp_last_data = 1'b0;
                n_checks++; if (kd_q.size() != 1) $display("FAIL both_prep_key got %0d pulses exp 1", kd_q.size()); else n_pass++;
            end
            w = 32'($urandom);
            s = rand_state();
            kd_q.delete(); dd_q.delete();
            start_jobs(1'b1, w, 1'b1, s, 1'(pass == 0), t0);
            if (!exp_last_data) begin
                dexp = DB + 1 + P; kexp = dexp + KB + 1 + P; first_done = dexp;
            end else begin
                kexp = KB + 1 + P; dexp = kexp + DB + 1 + P; first_done = kexp;
            end
            tick(KB + DB + 2 * P + 8);
            exp_key_sub  = sub_word(w);
            exp_data_sub = sub_state(s, 1'(pass == 0));
            n_checks++;
            if (kd_q.size() != 1 || kd_q[0] - t0 + 1 != kexp)
                $display("FAIL both_key_done got %0d pulses rel %0d exp 1 at %0d", kd_q.size(),
                         (kd_q.size() > 0) ? kd_q[0] - t0 + 1 : -1, kexp);
            else n_pass++;
            n_checks++;
            if (dd_q.size() != 1 || dd_q[0] - t0 + 1 != dexp)
                $display("FAIL both_data_done got %0d pulses rel %0d exp 1 at %0d", dd_q.size(),
                         (dd_q.size() > 0) ? dd_q[0] - t0 + 1 : -1, dexp);
            else n_pass++;
            n_checks++; if (key_sub !== exp_key_sub) $display("FAIL both_key_sub got %h exp %h", key_sub, exp_key_sub); else n_pass++;
            n_checks++; if (data_sub !== exp_data_sub) $display("FAIL both_data_sub got %h exp %h", data_sub, exp_data_sub); else n_pass++;
            if (pass == 1) begin
                bad = 0;
                for (int r = first_done + 1; r < kexp; r++)
                    if (enc_log[(t0 + r - 1) % 4096] !== 1'b1) bad++;
                n_checks++; if (bad != 0) $display("FAIL key_run_encrypt got %0d cycles low exp 0", bad); else n_pass++;
            end
            exp_last_data = (kexp > dexp) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_ignored();
        int t0;
        logic [8*KB-1:0] wa, wb;
        wa = 32'($urandom);
        wb = ~wa;
        kd_q.delete(); dd_q.delete();
        start_jobs(1'b1, wa, 1'b0, '0, 1'b0, t0);
        tick(1);
        n_checks++; if (key_ready !== 1'b0) $display("FAIL ignored_ready got %b exp 0", key_ready); else n_pass++;
        key_start = 1'b1; key_word = wb;
        tick(1);
        key_start = 1'b0;
        tick(KB + P + 6);
        exp_key_sub = sub_word(wa);
        exp_last_data = 1'b0;
        n_checks++; if (kd_q.size() != 1) $display("FAIL ignored_pulses got %0d exp 1", kd_q.size()); else n_pass++;
        n_checks++; if (key_sub !== exp_key_sub) $display("FAIL ignored_key_sub got %h exp %h", key_sub, exp_key_sub); else n_pass++;
        n_checks++; if (data_sub !== exp_data_sub) $display("FAIL ignored_data_sub got %h exp %h", data_sub, exp_data_sub); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int t0;
        logic [8*DB-1:0] s;
        kd_q.delete(); dd_q.delete();
        start_jobs(1'b0, '0, 1'b1, rand_state(), 1'b1, t0);
        tick(7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_key_sub = '0; exp_data_sub = '0; exp_last_data = 1'b1;
        n_checks++; if ({key_ready, data_ready, busy} !== 3'b110) $display("FAIL rst_mid_flags got %b exp 110", {key_ready, data_ready, busy}); else n_pass++;
        n_checks++; if (data_sub !== '0) $display("FAIL rst_mid_data_sub got %h exp 0", data_sub); else n_pass++;
        n_checks++; if ({sbox_a, sbox_encrypt} !== 9'h001) $display("FAIL rst_mid_sbox got %h/%b exp 00/1", sbox_a, sbox_encrypt); else n_pass++;
        tick(30);
        n_checks++; if (dd_q.size() != 0) $display("FAIL rst_mid_no_done got %0d pulses exp 0", dd_q.size()); else n_pass++;
        s = rand_state();
        start_jobs(1'b0, '0, 1'b1, s, 1'b0, t0);
        tick(DB + P + 3);
        exp_data_sub = sub_state(s, 1'b0);
        n_checks++;
        if (dd_q.size() != 1 || dd_q[0] - t0 + 1 != DB + 1 + P)
            $display("FAIL rst_fresh_done got %0d pulses rel %0d exp 1 at %0d", dd_q.size(),
                     (dd_q.size() > 0) ? dd_q[0] - t0 + 1 : -1, DB + 1 + P);
        else n_pass++;
        n_checks++; if (data_sub !== exp_data_sub) $display("FAIL rst_fresh_data_sub got %h exp %h", data_sub, exp_data_sub); else n_pass++;
    endtask

    initial begin
        build_tables();
        test_reset();
        test_key();
        test_data();
        test_both();
        test_ignored();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
